// File: rtl/bsg_mem_nr1w_one_hot_valid_if.sv
// Port bundle for the one-hot register file.
// Carries the write, invalidate and read-select requests, plus the read and valid-state responses.
interface bsg_mem_nr1w_one_hot_valid_if #(
    parameter int width_p      = 16,
    parameter int els_p        = 4,
    parameter int read_ports_p = 2
);
    localparam int lg_els_lp = $clog2(els_p + 1);

    logic [els_p-1:0]                     w_v;
    logic [width_p-1:0]                   w_mask;
    logic [width_p-1:0]                   w_data;
    logic [els_p-1:0]                     inv;
    logic [read_ports_p-1:0][els_p-1:0]   r_v;
    logic [read_ports_p-1:0][width_p-1:0] r_data;
    logic [read_ports_p-1:0]              r_hit;
    logic [els_p-1:0]                     valid;
    logic [lg_els_lp-1:0]                 valid_count;

    modport master (
        output w_v, w_mask, w_data, inv, r_v,
        input  r_data, r_hit, valid, valid_count
    );

    modport slave (
        input  w_v, w_mask, w_data, inv, r_v,
        output r_data, r_hit, valid, valid_count
    );
endinterface

// File: rtl/bsg_mem_nr1w_one_hot_valid.sv
// One-hot addressed N-read/1-write register file with per-entry valid bits, masked writes,
// bulk invalidate, optional write-to-read bypass and optional registered read outputs.

module bsg_mem_nr1w_one_hot_valid_rport #(
    parameter int width_p  = 16,
    parameter int els_p    = 4,
    parameter int bypass_p = 1
) (
    input  logic                          reset_n_i,
    input  logic [els_p-1:0][width_p-1:0] mem_i,
    input  logic [els_p-1:0]              valid_i,
    input  logic [els_p-1:0]              r_v_i,
    input  logic [els_p-1:0]              w_v_i,
    input  logic [width_p-1:0]            w_mask_i,
    input  logic [width_p-1:0]            w_data_i,
    output logic [width_p-1:0]            data_o,
    output logic                          hit_o
);
    logic byp;

    // A write held off by reset must not appear on the read side either.
    assign byp = (bypass_p != 0) && reset_n_i && (r_v_i == w_v_i) && (|w_v_i);

    always_comb begin
        data_o = '0;
        hit_o  = 1'b0;
        for (int i = 0; i < els_p; i++) begin
            if (r_v_i[i]) begin
                data_o = data_o | mem_i[i];
                hit_o  = hit_o | valid_i[i];
            end
        end
        if (byp) begin
            data_o = (data_o & ~w_mask_i) | (w_data_i & w_mask_i);
            hit_o  = 1'b1;
        end
    end
endmodule

module bsg_mem_nr1w_one_hot_valid #(
    parameter int width_p      = 16,
    parameter int els_p        = 4,
    parameter int read_ports_p = 2,
    parameter int bypass_p     = 1,
    parameter int read_reg_p   = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bsg_mem_nr1w_one_hot_valid_if.slave  m
);
    localparam int lg_els_lp = $clog2(els_p + 1);

    logic [els_p-1:0][width_p-1:0]        mem_q, mem_d;
    logic [els_p-1:0]                     valid_q, valid_d;
    logic [lg_els_lp-1:0]                 count;
    logic [read_ports_p-1:0][width_p-1:0] c_data;
    logic [read_ports_p-1:0]              c_hit;

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < els_p; i++) begin
            if (m.w_v[i]) mem_d[i] = (mem_q[i] & ~m.w_mask) | (m.w_data & m.w_mask);
        end
    end

    // Storage carries no reset; reset only blocks updates.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) mem_q <= mem_d;
    end

    // Write is OR'd in after the invalidate mask so it wins on a collision.
    assign valid_d = (valid_q & ~m.inv) | m.w_v;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) valid_q <= '0;
        else            valid_q <= valid_d;
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < els_p; i++) count = count + lg_els_lp'(valid_q[i]);
    end

    assign m.valid       = valid_q;
    assign m.valid_count = count;

    for (genvar p = 0; p < read_ports_p; p++) begin : g_rp
        bsg_mem_nr1w_one_hot_valid_rport #(
            .width_p  (width_p),
            .els_p    (els_p),
            .bypass_p (bypass_p)
        ) u_rp (
            .reset_n_i (reset_n_i),
            .mem_i     (mem_q),
            .valid_i   (valid_q),
            .r_v_i     (m.r_v[p]),
            .w_v_i     (m.w_v),
            .w_mask_i  (m.w_mask),
            .w_data_i  (m.w_data),
            .data_o    (c_data[p]),
            .hit_o     (c_hit[p])
        );

        a_r_onehot: assert property (@(negedge clk_i) disable iff (!reset_n_i) $onehot0(m.r_v[p]));
    end

    if (read_reg_p != 0) begin : g_rreg
        logic [read_ports_p-1:0][width_p-1:0] r_data_q;
        logic [read_ports_p-1:0]              r_hit_q;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_data_q <= '0;
                r_hit_q  <= '0;
            end else begin
                r_data_q <= c_data;
                r_hit_q  <= c_hit;
            end
        end

        assign m.r_data = r_data_q;
        assign m.r_hit  = r_hit_q;
    end else begin : g_rcomb
        assign m.r_data = c_data;
        assign m.r_hit  = c_hit;
    end

    a_w_onehot: assert property (@(negedge clk_i) disable iff (!reset_n_i) $onehot0(m.w_v));
endmodule

// File: tb/tb_bsg_mem_nr1w_one_hot_valid.sv
// Directed bench: three configurations (bypass/async, no-bypass/async, bypass/registered)
// driven by one shared stimulus set, each scenario checked inline.
module tb_bsg_mem_nr1w_one_hot_valid;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      w_v, inv;
    logic [15:0]     w_mask, w_data;
    logic [1:0][3:0] r_v;
    int              chk = 0;
    int              pass = 0;

    always #5 clk = ~clk;

    bsg_mem_nr1w_one_hot_valid_if #(.width_p(16), .els_p(4), .read_ports_p(2)) ia ();
    bsg_mem_nr1w_one_hot_valid_if #(.width_p(16), .els_p(4), .read_ports_p(2)) ib ();
    bsg_mem_nr1w_one_hot_valid_if #(.width_p(16), .els_p(4), .read_ports_p(2)) ic ();

    assign ia.w_v = w_v;  assign ia.w_mask = w_mask;  assign ia.w_data = w_data;
    assign ia.inv = inv;  assign ia.r_v = r_v;
    assign ib.w_v = w_v;  assign ib.w_mask = w_mask;  assign ib.w_data = w_data;
    assign ib.inv = inv;  assign ib.r_v = r_v;
    assign ic.w_v = w_v;  assign ic.w_mask = w_mask;  assign ic.w_data = w_data;
    assign ic.inv = inv;  assign ic.r_v = r_v;

    bsg_mem_nr1w_one_hot_valid #(.width_p(16), .els_p(4), .read_ports_p(2), .bypass_p(1), .read_reg_p(0))
        dut_a (.clk_i(clk), .reset_n_i(rst_n), .m(ia));
    bsg_mem_nr1w_one_hot_valid #(.width_p(16), .els_p(4), .read_ports_p(2), .bypass_p(0), .read_reg_p(0))
        dut_b (.clk_i(clk), .reset_n_i(rst_n), .m(ib));
    bsg_mem_nr1w_one_hot_valid #(.width_p(16), .els_p(4), .read_ports_p(2), .bypass_p(1), .read_reg_p(1))
        dut_c (.clk_i(clk), .reset_n_i(rst_n), .m(ic));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_w();
        w_v = '0; inv = '0; w_mask = '0; w_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; idle_w(); r_v = '0;
        #2 rst_n = 1'b0;
        r_v[0] = 4'b0001; r_v[1] = 4'b0001;
        #1;
        chk++; if (ia.r_hit !== 2'b00) $display("FAIL rst_hit: got %b exp %b", ia.r_hit, 2'b00); else pass++;
        chk++; if (ia.valid_count !== 3'd0) $display("FAIL rst_cnt: got %0d exp 0", ia.valid_count); else pass++;
        chk++; if (ia.valid !== 4'b0000) $display("FAIL rst_valid: got %b exp 0000", ia.valid); else pass++;
        chk++; if (ic.r_data !== 32'h0) $display("FAIL rst_regdata: got %h exp 00000000", ic.r_data); else pass++;
        chk++; if (ic.r_hit !== 2'b00) $display("FAIL rst_reghit: got %b exp 00", ic.r_hit); else pass++;
        // Multi-hot write while held in reset: ignored, and the assertion stays quiet.
        w_v = 4'b0011; w_mask = 16'hFFFF; w_data = 16'h1234;
        tick();
        idle_w();
        rst_n = 1'b1;
        #1;
        chk++; if (ia.valid !== 4'b0000) $display("FAIL rst_wignored: got %b exp 0000", ia.valid); else pass++;
        chk++; if (ia.r_hit !== 2'b00) $display("FAIL rst_hit_post: got %b exp 00", ia.r_hit); else pass++;
        r_v = '0;
        tick();
    endtask

    task automatic test_masked_write();
        w_v = 4'b0010; w_mask = 16'hFFFF; w_data = 16'hA5A5;
        tick();
        w_v = 4'b0010; w_mask = 16'h00FF; w_data = 16'h00FF;
        tick();
        idle_w();
        r_v[0] = 4'b0010; r_v[1] = 4'b0010;
        #1;
        chk++; if (ia.r_data[0] !== 16'hA5FF) $display("FAIL mw_rd0: got %h exp A5FF", ia.r_data[0]); else pass++;
        chk++; if (ia.r_data[1] !== 16'hA5FF) $display("FAIL mw_rd1: got %h exp A5FF", ia.r_data[1]); else pass++;
        chk++; if (ia.r_hit !== 2'b11) $display("FAIL mw_hit: got %b exp 11", ia.r_hit); else pass++;
        chk++; if (ia.valid_count !== 3'd1) $display("FAIL mw_cnt: got %0d exp 1", ia.valid_count); else pass++;
        chk++; if (ib.r_data[0] !== 16'hA5FF) $display("FAIL mw_nobyp: got %h exp A5FF", ib.r_data[0]); else pass++;
        tick();
        chk++; if (ic.r_data[1] !== 16'hA5FF) $display("FAIL mw_reg: got %h exp A5FF", ic.r_data[1]); else pass++;
        chk++; if (ic.r_hit !== 2'b11) $display("FAIL mw_reghit: got %b exp 11", ic.r_hit); else pass++;
        r_v = '0;
    endtask

    task automatic test_bypass();
        w_v = 4'b0100; w_mask = 16'hFFFF; w_data = 16'hBEEF;
        tick();
        idle_w(); inv = 4'b0100;
        tick();
        idle_w();
        w_v = 4'b0100; w_mask = 16'hFFFF; w_data = 16'h1234;
        r_v[0] = 4'b0100; r_v[1] = 4'b0000;
        #1;
        chk++; if (ia.r_data[0] !== 16'h1234) $display("FAIL byp_data: got %h exp 1234", ia.r_data[0]); else pass++;
        chk++; if (ia.r_hit[0] !== 1'b1) $display("FAIL byp_hit: got %b exp 1", ia.r_hit[0]); else pass++;
        chk++; if (ib.r_data[0] !== 16'hBEEF) $display("FAIL nobyp_data: got %h exp BEEF", ib.r_data[0]); else pass++;
        chk++; if (ib.r_hit[0] !== 1'b0) $display("FAIL nobyp_hit: got %b exp 0", ib.r_hit[0]); else pass++;
        chk++; if (ia.r_data[1] !== 16'h0) $display("FAIL zerohot_data: got %h exp 0000", ia.r_data[1]); else pass++;
        chk++; if (ia.r_hit[1] !== 1'b0) $display("FAIL zerohot_hit: got %b exp 0", ia.r_hit[1]); else pass++;
        tick();
        chk++; if (ic.r_data[0] !== 16'h1234) $display("FAIL regbyp_data: got %h exp 1234", ic.r_data[0]); else pass++;
        chk++; if (ic.r_hit[0] !== 1'b1) $display("FAIL regbyp_hit: got %b exp 1", ic.r_hit[0]); else pass++;
        // Partial-mask bypass merges with stored 1234.
        w_mask = 16'hFF00; w_data = 16'hABCD;
        #1;
        chk++; if (ia.r_data[0] !== 16'hAB34) $display("FAIL byp_merge: got %h exp AB34", ia.r_data[0]); else pass++;
        chk++; if (ib.r_data[0] !== 16'h1234) $display("FAIL nobyp_old: got %h exp 1234", ib.r_data[0]); else pass++;
        chk++; if (ib.r_hit[0] !== 1'b1) $display("FAIL nobyp_validnow: got %b exp 1", ib.r_hit[0]); else pass++;
        tick();
        idle_w();
        #1;
        chk++; if (ib.r_data[0] !== 16'hAB34) $display("FAIL merge_stored: got %h exp AB34", ib.r_data[0]); else pass++;
        r_v = '0;
    endtask

    task automatic test_inv_write();
        logic [15:0] fill [4];
        fill[0] = 16'h1111; fill[1] = 16'h2222; fill[2] = 16'h3333; fill[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            w_v = 4'(1 << i); w_mask = 16'hFFFF; w_data = fill[i];
            tick();
        end
        idle_w();
        #1;
        chk++; if (ia.valid !== 4'b1111) $display("FAIL fill_valid: got %b exp 1111", ia.valid); else pass++;
        chk++; if (ia.valid_count !== 3'd4) $display("FAIL fill_cnt: got %0d exp 4", ia.valid_count); else pass++;
        inv = 4'b1111; w_v = 4'b1000; w_mask = 16'hFFFF; w_data = 16'h8888;
        r_v[0] = 4'b0001; r_v[1] = 4'b0000;
        #1;
        chk++; if (ia.r_hit[0] !== 1'b1) $display("FAIL inv_nobyp: got %b exp 1", ia.r_hit[0]); else pass++;
        chk++; if (ia.r_data[0] !== 16'h1111) $display("FAIL inv_data: got %h exp 1111", ia.r_data[0]); else pass++;
        tick();
        chk++; if (ic.r_hit[0] !== 1'b1) $display("FAIL inv_reghit: got %b exp 1", ic.r_hit[0]); else pass++;
        idle_w();
        #1;
        chk++; if (ia.valid !== 4'b1000) $display("FAIL inv_valid: got %b exp 1000", ia.valid); else pass++;
        chk++; if (ia.valid_count !== 3'd1) $display("FAIL inv_cnt: got %0d exp 1", ia.valid_count); else pass++;
        chk++; if (ia.r_hit[0] !== 1'b0) $display("FAIL inv_hit: got %b exp 0", ia.r_hit[0]); else pass++;
        r_v = '0;
    endtask

    task automatic test_read_reg();
        w_v = 4'b0001; w_mask = 16'hFFFF; w_data = 16'h5A5A;
        tick();
        idle_w();
        r_v[0] = 4'b0001; r_v[1] = 4'b1000;
        #1;
        chk++; if (ic.r_data[0] !== 16'h0) $display("FAIL lat_early: got %h exp 0000", ic.r_data[0]); else pass++;
        chk++; if (ic.r_hit !== 2'b00) $display("FAIL lat_earlyhit: got %b exp 00", ic.r_hit); else pass++;
        chk++; if (ia.r_data[0] !== 16'h5A5A) $display("FAIL lat_async: got %h exp 5A5A", ia.r_data[0]); else pass++;
        tick();
        chk++; if (ic.r_data[0] !== 16'h5A5A) $display("FAIL lat_n1_0: got %h exp 5A5A", ic.r_data[0]); else pass++;
        chk++; if (ic.r_data[1] !== 16'h8888) $display("FAIL lat_n1_1: got %h exp 8888", ic.r_data[1]); else pass++;
        chk++; if (ic.r_hit !== 2'b11) $display("FAIL lat_n1_hit: got %b exp 11", ic.r_hit); else pass++;
        #2 rst_n = 1'b0;
        #1;
        chk++; if (ic.r_hit !== 2'b00) $display("FAIL midrst_hit: got %b exp 00", ic.r_hit); else pass++;
        chk++; if (ic.r_data !== 32'h0) $display("FAIL midrst_data: got %h exp 00000000", ic.r_data); else pass++;
        chk++; if (ia.valid_count !== 3'd0) $display("FAIL midrst_cnt: got %0d exp 0", ia.valid_count); else pass++;
        rst_n = 1'b1;
        r_v = '0;
    endtask

    task automatic test_nonhot_in_reset();
        tick();
        rst_n = 1'b0;
        w_v = 4'b0011; w_mask = 16'hFFFF; w_data = 16'h0000;
        r_v[0] = 4'b0101; r_v[1] = 4'b0011;
        #1;
        chk++; if (ia.r_data[0] !== 16'h7B7B) $display("FAIL or_rd0: got %h exp 7B7B", ia.r_data[0]); else pass++;
        chk++; if (ia.r_data[1] !== 16'h7A7A) $display("FAIL or_rd1: got %h exp 7A7A", ia.r_data[1]); else pass++;
        chk++; if (ia.r_hit !== 2'b00) $display("FAIL or_hit: got %b exp 00", ia.r_hit); else pass++;
        tick();
        idle_w();
        r_v[0] = 4'b0001; r_v[1] = 4'b0010;
        rst_n = 1'b1;
        #1;
        chk++; if (ia.r_data[0] !== 16'h5A5A) $display("FAIL rstw_e0: got %h exp 5A5A", ia.r_data[0]); else pass++;
        chk++; if (ia.r_data[1] !== 16'h2222) $display("FAIL rstw_e1: got %h exp 2222", ia.r_data[1]); else pass++;
        chk++; if (ia.valid !== 4'b0000) $display("FAIL rstw_valid: got %b exp 0000", ia.valid); else pass++;
        r_v = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no completion exp finish before 100000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_masked_write();
        test_bypass();
        test_inv_write();
        test_read_reg();
        test_nonhot_in_reset();
        tick();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
